// File: rtl/cpu_ad48_irq_ctrl.sv
// Interrupt controller: pending/mask registers, fixed-priority selection and a REQ/ACTIVE trap handshake.
// Define CPU_AD48_IRQ_EDGE_EN for rising-edge sources; otherwise sources are level sensitive.
module cpu_ad48_irq_ctrl #(
  parameter int unsigned NUM_IRQ        = 8,
  parameter int unsigned IDX_W          = 3,
  parameter logic [47:0] CAUSE_IRQ_FLAG = 48'h8000_0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               csr_ie,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  output logic [NUM_IRQ-1:0] irq_mask,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic               irq_req,
  output logic [47:0]        irq_cause,
  input  logic               irq_ack,
  input  logic               irq_eret,
  output logic               irq_active,
  output logic [IDX_W-1:0]   irq_active_idx
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_IRQ-1:0]   mask_q, mask_d;
  logic [NUM_IRQ-1:0]   pending_q, pending_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 req_q, req_d;
  logic                 active_q, active_d;
  logic [47:0]          cause_q, cause_d;

  logic [NUM_IRQ-1:0]   set_vec;
  logic [NUM_IRQ-1:0]   clr_vec;
  logic [NUM_IRQ-1:0]   eligible;
  logic [NUM_IRQ-1:0]   idx_onehot;
  logic [IDX_W-1:0]     sel_idx;

`ifdef CPU_AD48_IRQ_EDGE_EN
  logic [NUM_IRQ-1:0]   src_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) src_prev_q <= '0;
    else       src_prev_q <= irq_src;
  end

  assign set_vec = irq_src & ~src_prev_q;
`else
  assign set_vec = irq_src;
`endif

  assign eligible   = pending_q & mask_q;
  assign idx_onehot = {{(NUM_IRQ-1){1'b0}}, 1'b1} << idx_q;

  // Iterating downward lets the lowest-numbered eligible source overwrite the others.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    idx_d   = idx_q;
    clr_vec = '0;
    case (state_q)
      IDLE: begin
        if (csr_ie && (eligible != '0)) begin
          idx_d   = sel_idx;
          state_d = REQ;
        end
      end
      REQ: begin
        if (irq_ack) begin
          clr_vec = idx_onehot;
          state_d = ACTIVE;
        end else if (!csr_ie || ((eligible & idx_onehot) == '0)) begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (irq_eret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new set on the same bit as an acknowledge clear keeps the bit pending.
    pending_d = (pending_q & ~clr_vec) | set_vec;
    mask_d    = mask_we ? mask_wdata : mask_q;
    req_d     = (state_d == REQ);
    active_d  = (state_d == ACTIVE);
    cause_d   = CAUSE_IRQ_FLAG | 48'(idx_d);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      pending_q <= '0;
      idx_q     <= '0;
      req_q     <= 1'b0;
      active_q  <= 1'b0;
      cause_q   <= CAUSE_IRQ_FLAG;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      req_q     <= req_d;
      active_q  <= active_d;
      cause_q   <= cause_d;
    end
  end

  assign irq_mask       = mask_q;
  assign irq_pending    = pending_q;
  assign irq_req        = req_q;
  assign irq_active     = active_q;
  assign irq_active_idx = idx_q;
  assign irq_cause      = cause_q;

endmodule

// File: tb/tb_cpu_ad48_irq_ctrl.sv
// Directed bench for cpu_ad48_irq_ctrl; expected values are hand-computed per scenario.
module tb_cpu_ad48_irq_ctrl;

  localparam int unsigned NUM_IRQ = 8;
  localparam int unsigned IDX_W   = 3;
  localparam logic [47:0] FLAG    = 48'h8000_0000_0000;

  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_IRQ-1:0] irq_src;
  logic               csr_ie;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_wdata;
  logic [NUM_IRQ-1:0] irq_mask;
  logic [NUM_IRQ-1:0] irq_pending;
  logic               irq_req;
  logic [47:0]        irq_cause;
  logic               irq_ack;
  logic               irq_eret;
  logic               irq_active;
  logic [IDX_W-1:0]   irq_active_idx;

  int checks   = 0;
  int failures = 0;

  cpu_ad48_irq_ctrl #(.NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W), .CAUSE_IRQ_FLAG(FLAG)) dut (
    .clk            (clk),
    .reset          (reset),
    .irq_src        (irq_src),
    .csr_ie         (csr_ie),
    .mask_we        (mask_we),
    .mask_wdata     (mask_wdata),
    .irq_mask       (irq_mask),
    .irq_pending    (irq_pending),
    .irq_req        (irq_req),
    .irq_cause      (irq_cause),
    .irq_ack        (irq_ack),
    .irq_eret       (irq_eret),
    .irq_active     (irq_active),
    .irq_active_idx (irq_active_idx)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_cycle();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
  endtask

  task automatic eret_cycle();
    irq_eret = 1'b1; tick(); irq_eret = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; irq_src = '0; csr_ie = 1'b0; mask_we = 1'b0; mask_wdata = '0;
    irq_ack = 1'b0; irq_eret = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++; if (irq_mask !== 8'h00) begin failures++; $display("FAIL reset_mask got=%0h exp=0", irq_mask); end
    checks++; if (irq_pending !== 8'h00) begin failures++; $display("FAIL reset_pending got=%0h exp=0", irq_pending); end
    checks++; if (irq_req !== 1'b0 || irq_active !== 1'b0) begin failures++; $display("FAIL reset_req_active got=%0b%0b exp=00", irq_req, irq_active); end
    checks++; if (irq_active_idx !== 3'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", irq_active_idx); end
    checks++; if (irq_cause !== FLAG) begin failures++; $display("FAIL reset_cause got=%0h exp=%0h", irq_cause, FLAG); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    mask_we = 1'b1; mask_wdata = 8'hFF; tick(); mask_we = 1'b0;
    checks++; if (irq_mask !== 8'hFF) begin failures++; $display("FAIL basic_mask got=%0h exp=ff", irq_mask); end
    csr_ie = 1'b1; irq_src = 8'h20; tick(); irq_src = 8'h00;
    checks++; if (irq_req !== 1'b0 || irq_pending !== 8'h20) begin failures++; $display("FAIL basic_first_cycle req=%0b pend=%0h exp req=0 pend=20", irq_req, irq_pending); end
    tick();
    checks++; if (irq_req !== 1'b1) begin failures++; $display("FAIL basic_req got=%0b exp=1", irq_req); end
    checks++; if (irq_active_idx !== 3'd5) begin failures++; $display("FAIL basic_idx got=%0d exp=5", irq_active_idx); end
    checks++; if (irq_cause !== 48'h8000_0000_0005) begin failures++; $display("FAIL basic_cause got=%0h exp=800000000005", irq_cause); end
    tick();
    checks++; if (irq_req !== 1'b1 || irq_active_idx !== 3'd5) begin failures++; $display("FAIL basic_hold req=%0b idx=%0d exp req=1 idx=5", irq_req, irq_active_idx); end
    ack_cycle();
    checks++; if (irq_active !== 1'b1 || irq_req !== 1'b0 || irq_pending !== 8'h00) begin failures++; $display("FAIL basic_ack act=%0b req=%0b pend=%0h exp act=1 req=0 pend=0", irq_active, irq_req, irq_pending); end
    eret_cycle();
    checks++; if (irq_active !== 1'b0 || irq_req !== 1'b0) begin failures++; $display("FAIL basic_eret act=%0b req=%0b exp 0 0", irq_active, irq_req); end
  endtask

  task automatic test_priority();
    irq_src = 8'h14; tick(); irq_src = 8'h00; tick();
    checks++; if (irq_req !== 1'b1 || irq_active_idx !== 3'd2) begin failures++; $display("FAIL prio_first req=%0b idx=%0d exp req=1 idx=2", irq_req, irq_active_idx); end
    ack_cycle();
    checks++; if (irq_active !== 1'b1 || irq_pending !== 8'h10) begin failures++; $display("FAIL prio_ack1 act=%0b pend=%0h exp act=1 pend=10", irq_active, irq_pending); end
    eret_cycle();
    checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL prio_rearb_delay got=%0b exp=0", irq_req); end
    tick();
    checks++; if (irq_req !== 1'b1 || irq_active_idx !== 3'd4) begin failures++; $display("FAIL prio_second req=%0b idx=%0d exp req=1 idx=4", irq_req, irq_active_idx); end
    ack_cycle();
    checks++; if (irq_pending !== 8'h00) begin failures++; $display("FAIL prio_pending_end got=%0h exp=0", irq_pending); end
    eret_cycle();
  endtask

  task automatic test_withdraw();
    irq_src = 8'h08; tick(); irq_src = 8'h00; tick();
    checks++; if (irq_req !== 1'b1 || irq_active_idx !== 3'd3) begin failures++; $display("FAIL wd_req req=%0b idx=%0d exp req=1 idx=3", irq_req, irq_active_idx); end
    csr_ie = 1'b0; tick();
    checks++; if (irq_req !== 1'b0 || irq_active !== 1'b0 || irq_pending !== 8'h08) begin failures++; $display("FAIL wd_drop req=%0b act=%0b pend=%0h exp 0 0 08", irq_req, irq_active, irq_pending); end
    ack_cycle();
    checks++; if (irq_pending !== 8'h08 || irq_active !== 1'b0) begin failures++; $display("FAIL wd_stray_ack pend=%0h act=%0b exp pend=08 act=0", irq_pending, irq_active); end
    csr_ie = 1'b1; tick();
    checks++; if (irq_req !== 1'b1 || irq_active_idx !== 3'd3) begin failures++; $display("FAIL wd_rereq req=%0b idx=%0d exp req=1 idx=3", irq_req, irq_active_idx); end
    csr_ie = 1'b0; ack_cycle(); csr_ie = 1'b1;
    checks++; if (irq_active !== 1'b1 || irq_req !== 1'b0 || irq_pending !== 8'h00) begin failures++; $display("FAIL wd_ack_wins act=%0b req=%0b pend=%0h exp 1 0 00", irq_active, irq_req, irq_pending); end
    eret_cycle();
  endtask

  task automatic test_no_nesting();
    irq_src = 8'h04; tick(); irq_src = 8'h00; tick();
    ack_cycle();
    irq_src = 8'h01; tick(); irq_src = 8'h00; tick(); tick();
    checks++; if (irq_req !== 1'b0 || irq_active !== 1'b1 || irq_pending !== 8'h01) begin failures++; $display("FAIL nest_blocked req=%0b act=%0b pend=%0h exp 0 1 01", irq_req, irq_active, irq_pending); end
    eret_cycle();
    checks++; if (irq_req !== 1'b0 || irq_active !== 1'b0) begin failures++; $display("FAIL nest_after_eret req=%0b act=%0b exp 0 0", irq_req, irq_active); end
    tick();
    checks++; if (irq_req !== 1'b1 || irq_active_idx !== 3'd0 || irq_cause !== FLAG) begin failures++; $display("FAIL nest_served req=%0b idx=%0d cause=%0h exp 1 0 %0h", irq_req, irq_active_idx, irq_cause, FLAG); end
    ack_cycle(); eret_cycle();
  endtask

  task automatic test_mask();
    mask_we = 1'b1; mask_wdata = 8'h00; tick(); mask_we = 1'b0;
    irq_src = 8'h02; tick(); irq_src = 8'h00; tick(); tick();
    checks++; if (irq_pending !== 8'h02 || irq_req !== 1'b0) begin failures++; $display("FAIL mask_gated pend=%0h req=%0b exp pend=02 req=0", irq_pending, irq_req); end
    mask_we = 1'b1; mask_wdata = 8'h02; tick(); mask_we = 1'b0;
    checks++; if (irq_mask !== 8'h02 || irq_req !== 1'b0) begin failures++; $display("FAIL mask_update mask=%0h req=%0b exp mask=02 req=0", irq_mask, irq_req); end
    tick();
    checks++; if (irq_req !== 1'b1 || irq_active_idx !== 3'd1) begin failures++; $display("FAIL mask_unmasked req=%0b idx=%0d exp req=1 idx=1", irq_req, irq_active_idx); end
    ack_cycle(); eret_cycle();
    mask_we = 1'b1; mask_wdata = 8'hFF; tick(); mask_we = 1'b0;
  endtask

  task automatic test_hold_ack();
    logic [7:0] exp_pend;
`ifdef CPU_AD48_IRQ_EDGE_EN
    exp_pend = 8'h00;
`else
    exp_pend = 8'h02;
`endif
    irq_src = 8'h02; tick(); tick();
    checks++; if (irq_req !== 1'b1 || irq_active_idx !== 3'd1) begin failures++; $display("FAIL hold_req req=%0b idx=%0d exp req=1 idx=1", irq_req, irq_active_idx); end
    ack_cycle();
    checks++; if (irq_pending !== exp_pend || irq_active !== 1'b1) begin failures++; $display("FAIL hold_pending pend=%0h act=%0b exp pend=%0h act=1", irq_pending, irq_active, exp_pend); end
    irq_src = 8'h00;
  endtask

  task automatic test_reset_active();
    #2 reset = 1'b1;
    #1;
    checks++; if (irq_req !== 1'b0 || irq_active !== 1'b0) begin failures++; $display("FAIL rst_act_flags req=%0b act=%0b exp 0 0", irq_req, irq_active); end
    checks++; if (irq_active_idx !== 3'd0 || irq_cause !== FLAG) begin failures++; $display("FAIL rst_act_idx idx=%0d cause=%0h exp 0 %0h", irq_active_idx, irq_cause, FLAG); end
    checks++; if (irq_pending !== 8'h00 || irq_mask !== 8'h00) begin failures++; $display("FAIL rst_act_regs pend=%0h mask=%0h exp 0 0", irq_pending, irq_mask); end
    tick();
    reset = 1'b0;
    mask_we = 1'b1; mask_wdata = 8'hFF; tick(); mask_we = 1'b0;
    irq_src = 8'h40; tick(); irq_src = 8'h00; tick();
    checks++; if (irq_req !== 1'b1 || irq_active_idx !== 3'd6 || irq_cause !== 48'h8000_0000_0006) begin failures++; $display("FAIL rst_act_new req=%0b idx=%0d cause=%0h exp 1 6 800000000006", irq_req, irq_active_idx, irq_cause); end
    ack_cycle();
    checks++; if (irq_active !== 1'b1 || irq_pending !== 8'h00) begin failures++; $display("FAIL rst_act_ack act=%0b pend=%0h exp 1 0", irq_active, irq_pending); end
    eret_cycle();
    checks++; if (irq_active !== 1'b0 || irq_req !== 1'b0) begin failures++; $display("FAIL rst_act_eret act=%0b req=%0b exp 0 0", irq_active, irq_req); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_withdraw();
    test_no_nesting();
    test_mask();
    test_hold_ack();
    test_reset_active();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
